// File: rtl/ring_pkg.sv
// Shared FSM encoding and beat geometry for the ring refill arbiter.
package ring_pkg;

  localparam int BEAT_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after index 'last'.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IDX_W'((int'(last) + off) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_fill_arb.sv
// Shares one L2 read port among NUM_CORES ring ports, one refill line at a time.
// Optional per-core line counters are enabled by defining RING_FILL_PERF_EN.
module ring_fill_arb
  import ring_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_BEATS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  output logic [NUM_CORES-1:0]          core_ready,
  output logic [NUM_CORES-1:0]          fill_valid,
  output logic [DATA_W-1:0]             fill_data,
  output logic [$clog2(LINE_BEATS)-1:0] fill_beat,
  output logic                          fill_last,
  output logic                          l2_rd_en,
  output logic [ADDR_W-1:0]             l2_addr,
  input  logic                          l2_rd_valid,
  input  logic [DATA_W-1:0]             l2_rd_data,
  output logic                          busy
`ifdef RING_FILL_PERF_EN
  ,
  output logic [NUM_CORES*32-1:0]       perf_lines
`endif
);

  localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BEATS * BEAT_BYTES - 1);

  state_t                 state, state_next;
  logic [IDX_W-1:0]       last_owner, owner, grant_idx;
  logic [NUM_CORES-1:0]   owner_oh, grant;
  logic [ADDR_W-1:0]      base, req_addr;
  logic [BEAT_W-1:0]      beat;
  logic                   last_beat;

  rr_arbiter #(.N(NUM_CORES), .IDX_W(IDX_W)) u_rr (
    .req   (core_req),
    .last  (last_owner),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    req_addr  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_W'(i);
        req_addr  = core_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign last_beat = (beat == BEAT_W'(LINE_BEATS - 1));

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (|core_req) state_next = GRANT;
      GRANT:   state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (l2_rd_valid) state_next = last_beat ? DONE : ISSUE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset as well, so every output reads 0
      // immediately after rst and an abandoned beat leaves nothing behind.
      state      <= IDLE;
      last_owner <= IDX_W'(NUM_CORES - 1);
      owner      <= '0;
      owner_oh   <= '0;
      base       <= '0;
      beat       <= '0;
      fill_valid <= '0;
      fill_data  <= '0;
      fill_beat  <= '0;
      fill_last  <= 1'b0;
    end else begin
      state      <= state_next;
      fill_valid <= '0;
      fill_data  <= '0;
      fill_beat  <= '0;
      fill_last  <= 1'b0;
      case (state)
        IDLE: if (|core_req) begin
          owner    <= grant_idx;
          owner_oh <= grant;
          base     <= req_addr & ~LINE_MASK;
          beat     <= '0;
        end
        WAIT: if (l2_rd_valid) begin
          fill_valid <= owner_oh;
          fill_data  <= l2_rd_data;
          fill_beat  <= beat;
          fill_last  <= last_beat;
          if (!last_beat) beat <= beat + BEAT_W'(1);
        end
        DONE:    last_owner <= owner;
        default: ;
      endcase
    end
  end

  // Address and grant are gated by state so idle outputs stay at 0.
  assign core_ready = (state == GRANT) ? owner_oh : '0;
  assign l2_rd_en   = (state == ISSUE);
  assign l2_addr    = (state == ISSUE) ? base + ADDR_W'(beat) * ADDR_W'(BEAT_BYTES) : '0;
  assign busy       = (state != IDLE);

`ifdef RING_FILL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lines <= '0;
    end else if (state == DONE) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (owner_oh[i]) perf_lines[i*32 +: 32] <= perf_lines[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ring_fill_arb.sv
// Directed self-checking bench for ring_fill_arb with an in-bench L2 responder.
module tb_ring_fill_arb;

  localparam int NC = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LB = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     core_req;
  logic [NC*AW-1:0]  core_addr;
  logic [NC-1:0]     core_ready;
  logic [NC-1:0]     fill_valid;
  logic [DW-1:0]     fill_data;
  logic [3:0]        fill_beat;
  logic              fill_last;
  logic              l2_rd_en;
  logic [AW-1:0]     l2_addr;
  logic              l2_rd_valid;
  logic [DW-1:0]     l2_rd_data;
  logic              busy;
`ifdef RING_FILL_PERF_EN
  logic [NC*32-1:0]  perf_lines;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int line_tag = 0;

  ring_fill_arb #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .LINE_BEATS(LB)) dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_addr   (core_addr),
    .core_ready  (core_ready),
    .fill_valid  (fill_valid),
    .fill_data   (fill_data),
    .fill_beat   (fill_beat),
    .fill_last   (fill_last),
    .l2_rd_en    (l2_rd_en),
    .l2_addr     (l2_addr),
    .l2_rd_valid (l2_rd_valid),
    .l2_rd_data  (l2_rd_data),
    .busy        (busy)
`ifdef RING_FILL_PERF_EN
    ,
    .perf_lines  (perf_lines)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat_data(input int b);
    return {32'(line_tag), 32'h5A5A_0000 | 32'(b)};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One beat: find the read strobe, answer after 'lat' cycles, check the fill.
  task automatic do_beat(input logic [63:0] base, input logic [NC-1:0] oh, input int b,
                         input int lat, inout int extra, output bit ok);
    int w = 0;
    ok = 1'b0;
    while (!l2_rd_en && w < 20) begin
      tick();
      w++;
    end
    if (!l2_rd_en) begin
      check("rd_en_timeout", 64'd0, 64'd1);
      return;
    end
    check("l2_addr", l2_addr, base + 64'(b) * 64'd8);
    tick();
    for (int k = 1; k < lat; k++) begin
      if (l2_rd_en) extra++;
      tick();
    end
    if (l2_rd_en) extra++;
    l2_rd_valid = 1'b1;
    l2_rd_data  = beat_data(b);
    tick();
    l2_rd_valid = 1'b0;
    l2_rd_data  = '0;
    check("fill_valid", 64'(fill_valid), 64'(oh));
    check("fill_beat",  64'(fill_beat),  64'(b));
    check("fill_data",  fill_data,       beat_data(b));
    check("fill_last",  64'(fill_last),  64'(b == LB - 1));
    ok = 1'b1;
  endtask

  // Full line: wait for the grant, update requests, then all beats in order.
  task automatic run_line(input logic [NC-1:0] exp_oh, input logic [63:0] base, input bit var_lat,
                          input logic [NC-1:0] drop, input logic [NC-1:0] raise);
    int  w = 0;
    int  extra = 0;
    bit  ok;
    while (core_ready == '0 && w < 100) begin
      tick();
      w++;
    end
    check("core_ready", 64'(core_ready), 64'(exp_oh));
    if (core_ready == '0) return;
    core_req = (core_req & ~drop) | raise;
    tick();
    check("ready_pulse", 64'(core_ready), 64'd0);
    line_tag++;
    for (int b = 0; b < LB; b++) begin
      do_beat(base, exp_oh, b, var_lat ? (b % 7) + 1 : 1, extra, ok);
      if (!ok) return;
    end
    check("extra_rd", 64'(extra), 64'd0);
    check("done_busy", 64'(busy), 64'd1);
    tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  64'(busy),       64'd0);
    check({tag, "_ready"}, 64'(core_ready), 64'd0);
    check({tag, "_fv"},    64'(fill_valid), 64'd0);
    check({tag, "_fd"},    fill_data,       64'd0);
    check({tag, "_fb"},    64'(fill_beat),  64'd0);
    check({tag, "_fl"},    64'(fill_last),  64'd0);
    check({tag, "_rd"},    64'(l2_rd_en),   64'd0);
    check({tag, "_addr"},  l2_addr,         64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before 2 ms");
    $fatal(1);
  end

  initial begin
    bit ok;
    int extra;
    int w;
    rst         = 1'b1;
    core_req    = '0;
    core_addr   = '0;
    l2_rd_valid = 1'b0;
    l2_rd_data  = '0;
    do_reset();
    check_idle("reset");

    // Single core, aligned-down base, fixed latency 1.
    core_addr[0 +: AW] = 64'h1234;
    core_req = 2'b01;
    run_line(2'b01, 64'h1200, 1'b0, 2'b01, 2'b00);
    check("idle_after_line", 64'(busy), 64'd0);

    // Both request right after reset: core 0 first, then core 1.
    do_reset();
    core_addr[0  +: AW] = 64'h4000_0088;
    core_addr[AW +: AW] = 64'hFFFF_FFFF_FFFF_FFF8;
    core_req = 2'b11;
    run_line(2'b01, 64'h4000_0080, 1'b0, 2'b01, 2'b00);
    run_line(2'b10, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2'b10, 2'b00);

    // Core 1 held continuously, core 0 re-requests: grants 1, 0, 1.
    core_req = 2'b10;
    run_line(2'b10, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2'b00, 2'b01);
    run_line(2'b01, 64'h4000_0080, 1'b0, 2'b01, 2'b00);
    run_line(2'b10, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2'b10, 2'b00);

    // Variable L2 latency 1..7.
    core_addr[0 +: AW] = 64'h8000_0040;
    core_req = 2'b01;
    run_line(2'b01, 64'h8000_0000, 1'b1, 2'b01, 2'b00);

    // Reset while beat 5 is outstanding, then a late L2 response.
    core_addr[0 +: AW] = 64'h2000;
    core_req = 2'b01;
    w = 0;
    while (core_ready == '0 && w < 50) begin
      tick();
      w++;
    end
    check("rst_ready", 64'(core_ready), 64'h1);
    core_req = 2'b00;
    tick();
    line_tag++;
    extra = 0;
    for (int b = 0; b < 5; b++) do_beat(64'h2000, 2'b01, b, 2, extra, ok);
    check("rst_b5_rd", 64'(l2_rd_en), 64'd1);
    check("rst_b5_addr", l2_addr, 64'h2028);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");
    l2_rd_valid = 1'b1;
    l2_rd_data  = 64'hDEAD_BEEF_0000_0005;
    tick();
    l2_rd_valid = 1'b0;
    l2_rd_data  = '0;
    check("late_fv", 64'(fill_valid), 64'd0);
    check("late_busy", 64'(busy), 64'd0);
    tick();
    check("late_rd", 64'(l2_rd_en), 64'd0);
    core_addr[0 +: AW] = 64'h3000;
    core_req = 2'b01;
    run_line(2'b01, 64'h3000, 1'b0, 2'b01, 2'b00);

`ifdef RING_FILL_PERF_EN
    do_reset();
    check("perf_reset", 64'(perf_lines), 64'd0);
    for (int n = 0; n < 3; n++) begin
      core_req = 2'b01;
      run_line(2'b01, 64'h3000, 1'b0, 2'b01, 2'b00);
    end
    tick();
    check("perf_core0", 64'(perf_lines[0 +: 32]), 64'd3);
    check("perf_core1", 64'(perf_lines[32 +: 32]), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ring_fill_arb.md
RING_FILL_ARB -- requirements
Module: ring_fill_arb

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of core ring ports.
REQ-002 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-003 SHALL have parameter DATA_W, default 64, beat width (8 bytes).
REQ-004 SHALL have parameter LINE_BEATS, default 16, beats per refill line, power of two.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port core_req  input  NUM_CORES  per-core refill request, level, held until core_ready.
REQ-008 SHALL have port core_addr  input  NUM_CORES*ADDR_W  per-core refill byte address, core i at slice i.
REQ-009 SHALL have port core_ready  output  NUM_CORES  one-cycle grant pulse to the owning core.
REQ-010 SHALL have port fill_valid  output  NUM_CORES  one-hot beat strobe to the owner.
REQ-011 SHALL have port fill_data  output  DATA_W  beat payload, shared by all cores.
REQ-012 SHALL have port fill_beat  output  $clog2(LINE_BEATS)  index of the current beat.
REQ-013 SHALL have port fill_last  output  1  high with the final beat of a line.
REQ-014 SHALL have port l2_rd_en  output  1  one-cycle L2 read strobe.
REQ-015 SHALL have port l2_addr  output  ADDR_W  L2 beat byte address.
REQ-016 SHALL have port l2_rd_valid  input  1  L2 read data valid, latency of 1 or more cycles.
REQ-017 SHALL have port l2_rd_data  input  DATA_W  L2 read data.
REQ-018 SHALL have port busy  output  1  high while any state other than IDLE is active.

Function
REQ-019 SHALL use FSM states IDLE, GRANT, ISSUE, WAIT, DONE.
REQ-020 IDLE: on any core_req set, SHALL pick the owner by round-robin starting at last_owner+1 modulo NUM_CORES, latch line base = core_addr & ~(LINE_BEATS*8-1), clear beat, and go to GRANT.
REQ-021 GRANT: SHALL pulse core_ready[owner] for exactly one cycle, then go to ISSUE.
REQ-022 ISSUE: SHALL assert l2_rd_en for one cycle with l2_addr = base + beat*8, then go to WAIT.
REQ-023 WAIT: on l2_rd_valid, SHALL register fill_data=l2_rd_data, fill_beat=beat, fill_valid=one-hot(owner), and fill_last=(beat==LINE_BEATS-1), each for one cycle.
REQ-024 WAIT: SHALL go to DONE after the last beat; otherwise SHALL increment beat and go to ISSUE.
REQ-025 DONE: SHALL set last_owner=owner and go to IDLE; total line latency = 3 + sum(beat L2 latency + 1) + 1 cycles.
REQ-026 Exactly one L2 read SHALL be outstanding at a time.
REQ-027 SHALL ignore l2_rd_valid outside WAIT.
REQ-028 SHALL ignore core_req changes while busy; a request dropped mid-line SHALL still have its line completed.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-030 rst SHALL force IDLE, including mid-line, and SHALL abandon any outstanding beat.
REQ-031 rst SHALL drive all outputs to 0 and set last_owner=NUM_CORES-1, so core 0 is granted first.

Configuration
REQ-032 With RING_FILL_PERF_EN defined, SHALL add output perf_lines (NUM_CORES*32), per-core completed-line counters incremented in DONE, wrapping, cleared by rst.
REQ-033 Without RING_FILL_PERF_EN, perf_lines and its logic SHALL be absent.

Structure
REQ-034 FSM state encoding and the beat-size constant (8 bytes) SHALL reside in shared package ring_pkg.
REQ-035 Round-robin selection SHALL be the sub-module rr_arbiter (req, last, grant one-hot), reusable elsewhere.

Verification
REQ-036 Core0 req with addr 0x1234, LINE_BEATS=16, L2 latency 1 -> core_ready[0] pulse; l2_addr 0x1200..0x1278 step 8; 16 fill_valid[0] beats; fill_last on beat 15.
REQ-037 Both cores request simultaneously after reset -> core 0 is served first, then core 1; fill_valid never hits core 1 during core 0's line.
REQ-038 Core 1 keeps requesting continuously while core 0 requests again -> grants alternate 1,0,1.
REQ-039 rst asserted at beat 5 with L2 data pending -> next cycle IDLE, all outputs 0, a late l2_rd_valid is ignored.
REQ-040 Variable L2 latency 1..7 cycles -> exactly one l2_rd_en per beat, beats in order 0..15.
REQ-041 With RING_FILL_PERF_EN defined, 3 lines for core 0 -> perf_lines slice 0 equals 3, slice 1 equals 0.
